// File: rtl/turn_pkg.sv
// ---------------------------------------------------------------------------
// turn_pkg : state codes and light-face codes shared with the light sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package turn_pkg;

   localparam logic [3:0] ST_MG      = 4'd0;
   localparam logic [3:0] ST_MY      = 4'd1;
   localparam logic [3:0] ST_ALLRED1 = 4'd2;
   localparam logic [3:0] ST_SG      = 4'd3;
   localparam logic [3:0] ST_SY      = 4'd4;
   localparam logic [3:0] ST_ALLRED2 = 4'd5;
   localparam logic [3:0] ST_MTG     = 4'd6;
   localparam logic [3:0] ST_MTY     = 4'd7;
   localparam logic [3:0] ST_STG     = 4'd8;
   localparam logic [3:0] ST_STY     = 4'd9;
   localparam logic [3:0] ST_INITOFF = 4'd10;
   localparam logic [3:0] ST_INITON  = 4'd11;

   localparam logic [2:0] LF_OFF    = 3'b000;
   localparam logic [2:0] LF_RED    = 3'b100;
   localparam logic [2:0] LF_YELLOW = 3'b010;
   localparam logic [2:0] LF_GREEN  = 3'b001;
   localparam logic [2:0] LF_LARROW = 3'b011;

   function automatic logic is_init_state(input logic [3:0] st);
      return (st == ST_INITOFF) || (st == ST_INITON);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer, stability counter, debounced level, rise pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
   parameter logic [31:0] DEB_CYCLES = 32'd1000000
) (
   input  logic clk,
   input  logic res_i,     // asynchronous, active-low
   input  logic btn_i,
   output logic rise_o
);

   localparam int CW = (DEB_CYCLES > 32'd1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 32'd1);

   logic [1:0]    sync_q;
   logic [1:0]    vld_q;
   logic          armed_q;
   logic          level_q;
   logic          rise_q;
   logic [CW-1:0] cnt_q;

   // A rise is only reported once the button has been seen released after
   // reset, so a press held across reset never produces a request.
   always_ff @(posedge clk or negedge res_i) begin
      if (!res_i) begin
         sync_q  <= 2'b00;
         vld_q   <= 2'b00;
         armed_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         vld_q  <= {vld_q[0], 1'b1};
         rise_q <= 1'b0;
         if (vld_q[1] && !sync_q[1] && !level_q)
            armed_q <= 1'b1;
         if (sync_q[1] != level_q) begin
            if (cnt_q == DEB_LAST) begin
               level_q <= sync_q[1];
               cnt_q   <= '0;
               rise_q  <= sync_q[1] & armed_q;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/turn_req_ctrl.sv
// ---------------------------------------------------------------------------
// turn_req_ctrl : latches left-turn requests for the sequencer, clears on service.
// Optional request expiry when TURN_REQ_EXPIRE_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module turn_req_ctrl
   import turn_pkg::*;
#(
   parameter logic [31:0] DEB_CYCLES    = 32'd1000000,
   parameter logic [31:0] EXPIRE_CYCLES = 32'd3000000000
) (
   input  logic       clk,
   input  logic       res,
   input  logic       mlt_btn,
   input  logic       slt_btn,
   input  logic [3:0] state,
   output logic       MLTReg,
   output logic       SLTReg,
   output logic       mlt_served,
   output logic       slt_served
);

   logic [1:0] rise_w;
   logic [1:0] req_w;
   logic [1:0] srv_w;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mlt_deb (
      .clk    (clk),
      .res_i  (res),
      .btn_i  (mlt_btn),
      .rise_o (rise_w[0])
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_slt_deb (
      .clk    (clk),
      .res_i  (res),
      .btn_i  (slt_btn),
      .rise_o (rise_w[1])
   );

   // Index 0 is the main road, index 1 the side road.
   for (genvar d = 0; d < 2; d++) begin : g_dir
      localparam logic [3:0] TG = (d == 0) ? ST_MTG : ST_STG;
      localparam logic [3:0] TY = (d == 0) ? ST_MTY : ST_STY;

      logic req_q, req_d, srv_q;
      logic clr_w, set_w, exp_hit_w;

      assign clr_w = req_q && (state == TG);
      assign set_w = rise_w[d] && (state != TG) && (state != TY);

`ifdef TURN_REQ_EXPIRE_EN
      logic [31:0] exp_q;

      assign exp_hit_w = req_q && (exp_q == EXPIRE_CYCLES - 32'd1);

      always_ff @(posedge clk or negedge res) begin
         if (!res)
            exp_q <= 32'd0;
         else if (!req_q || set_w)
            exp_q <= 32'd0;
         else
            exp_q <= exp_q + 32'd1;
      end
`else
      assign exp_hit_w = 1'b0;
`endif

      always_comb begin
         req_d = req_q;
         if (is_init_state(state))
            req_d = 1'b0;
         else if (clr_w)
            req_d = 1'b0;
         else if (set_w)
            req_d = 1'b1;
         else if (exp_hit_w)
            req_d = 1'b0;
      end

      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            req_q <= 1'b0;
            srv_q <= 1'b0;
         end else begin
            req_q <= req_d;
            srv_q <= clr_w;
         end
      end

      assign req_w[d] = req_q;
      assign srv_w[d] = srv_q;
   end

`ifndef TURN_REQ_EXPIRE_EN
   logic unused_expire;
   assign unused_expire = ^EXPIRE_CYCLES;
`endif

   assign MLTReg     = req_w[0];
   assign SLTReg     = req_w[1];
   assign mlt_served = srv_w[0];
   assign slt_served = srv_w[1];

endmodule

`default_nettype wire

// File: tb/tb_turn_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_turn_req_ctrl : directed self-checking bench for turn_req_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_turn_req_ctrl;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       mlt_btn = 1'b0;
   logic       slt_btn = 1'b0;
   logic [3:0] state = 4'd2;
   logic       MLTReg, SLTReg, mlt_served, slt_served;

   int n_checks = 0;
   int n_errors = 0;

   turn_req_ctrl #(
      .DEB_CYCLES    (32'd4),
      .EXPIRE_CYCLES (32'd20)
   ) dut (
      .clk        (clk),
      .res        (res),
      .mlt_btn    (mlt_btn),
      .slt_btn    (slt_btn),
      .state      (state),
      .MLTReg     (MLTReg),
      .SLTReg     (SLTReg),
      .mlt_served (mlt_served),
      .slt_served (slt_served)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mlt;
      logic       slt;
      logic [3:0] st;
      logic       e_m;
      logic       e_s;
      logic       e_ms;
      logic       e_ss;
   } vec_t;

   vec_t tv[16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic m, input logic s,
                           input logic ms, input logic ss);
      chk(nm, int'({MLTReg, SLTReg, mlt_served, slt_served}), int'({m, s, ms, ss}));
   endtask

   // sel: 0 = MLTReg, 1 = SLTReg, 2 = either; n = cycles waited or -1 on timeout
   task automatic wait_set(input int sel, input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         step();
         if ((sel == 0 && MLTReg) || (sel == 1 && SLTReg) ||
             (sel == 2 && (MLTReg || SLTReg))) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int n, bad, served, gone;

      // Main-road press at state 2, then service at state 6.
      tv[0]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[1]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[2]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[3]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[4]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[5]  = '{1, 0, 4'd2, 0, 0, 0, 0};
      tv[6]  = '{0, 0, 4'd2, 1, 0, 0, 0};
      tv[7]  = '{0, 0, 4'd2, 1, 0, 0, 0};
      tv[8]  = '{0, 0, 4'd6, 0, 0, 1, 0};
      tv[9]  = '{0, 0, 4'd6, 0, 0, 0, 0};
      tv[10] = '{0, 0, 4'd7, 0, 0, 0, 0};
      tv[11] = '{0, 0, 4'd2, 0, 0, 0, 0};
      tv[12] = '{0, 0, 4'd2, 0, 0, 0, 0};
      tv[13] = '{0, 0, 4'd2, 0, 0, 0, 0};
      tv[14] = '{0, 0, 4'd2, 0, 0, 0, 0};
      tv[15] = '{0, 0, 4'd2, 0, 0, 0, 0};

      // Reset state
      #2;
      chk_outs("reset_async", 0, 0, 0, 0);
      idle(3);
      #2 res = 1'b1;
      idle(5);
      chk_outs("reset_idle", 0, 0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         mlt_btn = tv[i].mlt;
         slt_btn = tv[i].slt;
         state   = tv[i].st;
         step();
         chk_outs($sformatf("vec%0d", i), tv[i].e_m, tv[i].e_s, tv[i].e_ms, tv[i].e_ss);
      end

      // Bouncing side button never settles
      state = 4'd3;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         slt_btn = ((k / 2) % 2 == 0);
         step();
         if (SLTReg) bad++;
      end
      slt_btn = 1'b0;
      idle(8);
      chk("bounce_cycles_set", bad, 0);
      chk("bounce_final", int'(SLTReg), 0);

      // Side press during its own turn-green is ignored
      state = 4'd8;
      slt_btn = 1'b1;
      bad = 0;
      for (int k = 0; k < 8; k++) begin step(); if (SLTReg) bad++; end
      slt_btn = 1'b0;
      for (int k = 0; k < 8; k++) begin step(); if (SLTReg) bad++; end
      chk("stg_press_ignored", bad, 0);
      state = 4'd3;
      slt_btn = 1'b1;
      wait_set(1, 12, n);
      chk("slt_set_latency", n, 7);
      state = 4'd8;
      step();
      chk_outs("slt_serve", 0, 0, 0, 1);
      step();
      chk_outs("slt_serve_after", 0, 0, 0, 0);
      slt_btn = 1'b0;
      state = 4'd3;
      idle(10);

      // Init states hold both requests low
      state = 4'd11;
      mlt_btn = 1'b1;
      slt_btn = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin step(); if (MLTReg || SLTReg) bad++; end
      mlt_btn = 1'b0;
      slt_btn = 1'b0;
      for (int k = 0; k < 10; k++) begin step(); if (MLTReg || SLTReg) bad++; end
      chk("init_hold", bad, 0);

      // Simultaneous presses set both on the same cycle
      state = 4'd0;
      mlt_btn = 1'b1;
      slt_btn = 1'b1;
      wait_set(2, 12, n);
      chk("both_latency", n, 7);
      chk_outs("both_set", 1, 1, 0, 0);
      state = 4'd6;
      step();
      chk_outs("both_serve_m", 0, 1, 1, 0);
      state = 4'd8;
      step();
      chk_outs("both_serve_s", 0, 0, 0, 1);
      state = 4'd2;
      step();
      state = 4'd6;
      step();
      chk_outs("no_pulse_when_clear", 0, 0, 0, 0);
      mlt_btn = 1'b0;
      slt_btn = 1'b0;
      state = 4'd2;
      idle(10);

      // Asynchronous reset with a pending request, button held through release
      mlt_btn = 1'b1;
      wait_set(0, 12, n);
      chk("pre_reset_set", n, 7);
      #2 res = 1'b0;
      #1;
      chk_outs("reset_mid", 0, 0, 0, 0);
      idle(3);
      #2 res = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin step(); if (MLTReg) bad++; end
      chk("held_through_reset", bad, 0);
      mlt_btn = 1'b0;
      idle(10);
      mlt_btn = 1'b1;
      wait_set(0, 12, n);
      chk("fresh_press_latency", n, 7);

      // Pending request held at state 3: expiry or indefinite hold
      state = 4'd3;
      mlt_btn = 1'b0;
      served = 0;
      gone = -1;
`ifdef TURN_REQ_EXPIRE_EN
      for (int k = 1; k <= 30; k++) begin
         step();
         if (mlt_served) served++;
         if (!MLTReg && gone < 0) gone = k;
      end
      chk("expire_cycles", gone, 20);
      chk("expire_no_pulse", served, 0);
`else
      for (int k = 1; k <= 100; k++) begin
         step();
         if (mlt_served) served++;
         if (!MLTReg && gone < 0) gone = k;
      end
      chk("hold_100_cleared_at", gone, -1);
      chk("hold_100_no_pulse", served, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/turn_req_ctrl.md
TURN_REQ_CTRL -- requirements
Module: turn_req_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning the number of consecutive stable cycles (10 ms at 100 MHz) a button must hold before a change is accepted.
REQ-002 SHALL have parameter EXPIRE_CYCLES, default 3000000000, meaning the pending-request lifetime in cycles; used only when the expiry feature is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port res, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port mlt_btn, input, 1 bit: raw, asynchronous main-road left-turn pushbutton, active-high.
REQ-006 SHALL have port slt_btn, input, 1 bit: raw, asynchronous side-road left-turn pushbutton, active-high.
REQ-007 SHALL have port state, input, 4 bits: current light-sequencer state code.
REQ-008 SHALL have port MLTReg, output, 1 bit: latched main-road left-turn request to the sequencer.
REQ-009 SHALL have port SLTReg, output, 1 bit: latched side-road left-turn request to the sequencer.
REQ-010 SHALL have port mlt_served, output, 1 bit: one-cycle pulse when the main request is cleared by service.
REQ-011 SHALL have port slt_served, output, 1 bit: one-cycle pulse when the side request is cleared by service.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a debouncer; the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-013 SHALL set the request for a direction on the cycle after a debounced 0->1 edge for that direction; holding the button SHALL NOT re-trigger.
REQ-014 SHALL clear MLTReg and pulse mlt_served for one cycle on the first cycle state == MTG (6); SLTReg/slt_served SHALL behave the same on state == STG (8).
REQ-015 SHALL ignore a debounced edge arriving while its direction is in its turn-green or turn-yellow phase (main: 6/7; side: 8/9).
REQ-016 SHALL give clear priority over set when both occur in the same cycle.
REQ-017 SHALL hold both requests at 0, and ignore edges, while state is INITOFF (10) or INITON (11).
REQ-018 SHALL treat the two directions independently; simultaneous presses SHALL set both requests.
REQ-019 SHALL generate served pulses only on an actual 1->0 clear of a set request; no pulse if the request was already 0.

Reset
REQ-020 SHALL, while res = 0, force MLTReg, SLTReg, mlt_served and slt_served to 0, zero all debounce and expiry counters, and reset the synchronizers and debounced levels to 0.
REQ-021 SHALL, on a mid-press reset, require a fresh debounced rising edge after reset release before setting a request.

Configuration
REQ-022 SHALL, with TURN_REQ_EXPIRE_EN defined, clear a pending request without a served pulse after EXPIRE_CYCLES cycles pending; the counter restarts at each set.
REQ-023 SHALL, without TURN_REQ_EXPIRE_EN, hold requests until served or reset, and synthesize no expiry counters.

Structure
REQ-024 SHALL take the state-code localparams (0-11) and the light-face codes from shared package turn_pkg, also used by the sequencer.
REQ-025 SHALL implement debounce in one sub-module, btn_debounce (synchronizer, counter, level, rise pulse), instantiated twice.

Verification (DEB_CYCLES = 4, EXPIRE_CYCLES = 20)
REQ-026 SHALL cover: mlt_btn high for 6 cycles with state = 2 -> MLTReg = 1 within 4+2+1 cycles; then state = 6 -> MLTReg = 0, mlt_served pulses once.
REQ-027 SHALL cover: slt_btn toggling every 2 cycles for 20 cycles -> SLTReg stays 0.
REQ-028 SHALL cover: slt_btn pressed while state = 8 -> SLTReg stays 0; pressed again at state = 3 -> SLTReg = 1.
REQ-029 SHALL cover: state = 11 with both buttons pressed -> both requests 0; state = 0 with both pressed -> both 1 on the same cycle.
REQ-030 SHALL cover: res pulled low with MLTReg = 1 mid-count -> all outputs 0 immediately (asynchronous); button still held at release -> no request.
REQ-031 SHALL cover, with TURN_REQ_EXPIRE_EN: request set and state held at 3 -> request 0 after 20 cycles, no served pulse; without the macro -> request still 1 at 100 cycles.
